sap_controller: RTL and testbench

Controller-sequencer for the 4-bit bus datapath: it issues the control strobes that the accumulator and other bus registers respond to. These include EnableA, LatchA, the ALU strobes, the memory-address latch and the output latch. It holds the program counter and the instruction register, and runs a fixed six-state machine-cycle ring (T1..T6) per instruction. It sits on the shared bus opposite the accumulator, register B, RAM and the output port. It initiates every transfer; those registers only respond.

---
 rtl/sap_controller.sv | 125 ++++++++++++
 tb/tb_sap_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sap_controller.sv
// Controller-sequencer for the 4-bit SAP bus datapath: owns PC, IR and the T1..T6 ring,
// and decodes every bus/latch strobe combinationally from ring state, opcode and halt.
module sap_controller (
  input  logic       MainClock,
  input  logic       Clear,
  input  logic [7:0] BusIn,
  output logic [3:0] BusOut,
  output logic       Ep,
  output logic       Cp,
  output logic       LatchM,
  output logic       CE,
  output logic       LatchI,
  output logic       EnableI,
  output logic       LatchA,
  output logic       EnableA,
  output logic       LatchB,
  output logic       Su,
  output logic       Eu,
  output logic       LatchO,
  output logic       Halt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tStateT;

  typedef enum logic [3:0] {
    OpLda = 4'h0,
    OpAdd = 4'h1,
    OpSub = 4'h2,
    OpOut = 4'hE,
    OpHlt = 4'hF
  } opT;

  tStateT     state, nextState;
  logic [3:0] pc;
  logic [7:0] ir;
  logic       halted;

  always_ff @(posedge MainClock) begin
    if (Clear) state <= T1;
    else       state <= nextState;
  end

  always_ff @(posedge MainClock) begin
    if (Clear) begin
      pc     <= '0;
      ir     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (state == T2) pc <= pc + 4'd1;
      if (state == T3) ir <= BusIn;
      if (state == T4 && ir[7:4] == OpHlt) halted <= 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    if (!halted) begin
      case (state)
        T1:      nextState = T2;
        T2:      nextState = T3;
        T3:      nextState = T4;
        T4:      nextState = T5;
        T5:      nextState = T6;
        T6:      nextState = T1;
        default: nextState = T1;
      endcase
    end
  end

  // Clear and the halted flag both gate every strobe, so nothing drives the bus in either case.
  always_comb begin
    Ep      = 1'b0;
    Cp      = 1'b0;
    LatchM  = 1'b0;
    CE      = 1'b0;
    LatchI  = 1'b0;
    EnableI = 1'b0;
    LatchA  = 1'b0;
    EnableA = 1'b0;
    LatchB  = 1'b0;
    Su      = 1'b0;
    Eu      = 1'b0;
    LatchO  = 1'b0;
    if (!Clear && !halted) begin
      case (state)
        T1: begin Ep = 1'b1; LatchM = 1'b1; end
        T2: Cp = 1'b1;
        T3: begin CE = 1'b1; LatchI = 1'b1; end
        T4: begin
          case (ir[7:4])
            OpLda, OpAdd, OpSub: begin EnableI = 1'b1; LatchM = 1'b1; end
            OpOut:               begin EnableA = 1'b1; LatchO = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (ir[7:4])
            OpLda:        begin CE = 1'b1; LatchA = 1'b1; end
            OpAdd, OpSub: begin CE = 1'b1; LatchB = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (ir[7:4])
            OpAdd: begin Eu = 1'b1; LatchA = 1'b1; end
            OpSub: begin Eu = 1'b1; LatchA = 1'b1; Su = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign Halt   = halted & ~Clear;
  assign BusOut = Ep ? pc : (EnableI ? ir[3:0] : 'z);

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: per-cycle expected strobes/bus/halt pushed to a
// scoreboard queue as stimulus is driven, popped and compared just after the falling edge.
module tb_sap_controller;

  logic       MainClock;
  logic       Clear;
  logic [7:0] BusIn;
  wire  [3:0] busOut;
  logic Ep, Cp, LatchM, CE, LatchI, EnableI, LatchA, EnableA, LatchB, Su, Eu, LatchO, Halt;

  sap_controller dut (
    .MainClock(MainClock), .Clear(Clear), .BusIn(BusIn), .BusOut(busOut),
    .Ep(Ep), .Cp(Cp), .LatchM(LatchM), .CE(CE), .LatchI(LatchI), .EnableI(EnableI),
    .LatchA(LatchA), .EnableA(EnableA), .LatchB(LatchB), .Su(Su), .Eu(Eu),
    .LatchO(LatchO), .Halt(Halt)
  );

  // Strobe vector bit order: Ep Cp LatchM CE LatchI EnableI LatchA EnableA LatchB Su Eu LatchO
  localparam logic [11:0] SEP = 12'h800, SCP = 12'h400, SLM = 12'h200, SCE = 12'h100;
  localparam logic [11:0] SLI = 12'h080, SEI = 12'h040, SLA = 12'h020, SEA = 12'h010;
  localparam logic [11:0] SLB = 12'h008, SSU = 12'h004, SEU = 12'h002, SLO = 12'h001;

  typedef struct {
    logic        clr;
    logic [7:0]  bin;
    logic [11:0] strb;
    logic        halt;
    logic        drv;
    logic [3:0]  bus;
  } vecT;

  vecT        sbQ[$];
  vecT        ldaTab[7];
  int         errors = 0;
  int         checks = 0;
  int         cycleNo = 0;
  logic [3:0] pcModel = 4'h0;

  initial begin
    MainClock = 1'b0;
    forever #5 MainClock = ~MainClock;
  end

  function automatic vecT mk(logic clr, logic [7:0] bin, logic [11:0] strb,
                             logic halt, logic drv, logic [3:0] bus);
    vecT v;
    v.clr = clr; v.bin = bin; v.strb = strb; v.halt = halt; v.drv = drv; v.bus = bus;
    return v;
  endfunction

  // Expected outputs for ring state t of an instruction, straight from the opcode table.
  function automatic vecT expT(int t, logic [7:0] instr, logic [3:0] pc, logic [7:0] bin);
    vecT v;
    v = mk(1'b0, bin, '0, 1'b0, 1'b0, 4'h0);
    case (t)
      1: begin v.strb = SEP | SLM; v.drv = 1'b1; v.bus = pc; end
      2: v.strb = SCP;
      3: v.strb = SCE | SLI;
      4: begin
        if (instr[7:4] == 4'h0 || instr[7:4] == 4'h1 || instr[7:4] == 4'h2) begin
          v.strb = SEI | SLM; v.drv = 1'b1; v.bus = instr[3:0];
        end else if (instr[7:4] == 4'hE) v.strb = SEA | SLO;
      end
      5: begin
        if (instr[7:4] == 4'h0) v.strb = SCE | SLA;
        else if (instr[7:4] == 4'h1 || instr[7:4] == 4'h2) v.strb = SCE | SLB;
      end
      6: begin
        if (instr[7:4] == 4'h1) v.strb = SEU | SLA;
        else if (instr[7:4] == 4'h2) v.strb = SEU | SLA | SSU;
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic checkOut();
    vecT         e;
    logic [11:0] act;
    act = {Ep, Cp, LatchM, CE, LatchI, EnableI, LatchA, EnableA, LatchB, Su, Eu, LatchO};
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("FAIL scoreboard cycle %0d: got empty queue, need one entry", cycleNo);
      return;
    end
    e = sbQ.pop_front();
    if (act !== e.strb) begin
      errors++;
      $display("FAIL strobes cycle %0d: got %012b need %012b", cycleNo, act, e.strb);
    end
    checks++;
    if (Halt !== e.halt) begin
      errors++;
      $display("FAIL halt cycle %0d: got %b need %b", cycleNo, Halt, e.halt);
    end
    if (e.drv) begin
      checks++;
      if (busOut !== e.bus) begin
        errors++;
        $display("FAIL busOut cycle %0d: got %b need %b", cycleNo, busOut, e.bus);
      end
    end
    checks++;
    if ($countones({Ep, EnableI, CE, EnableA, Eu}) > 1) begin
      errors++;
      $display("FAIL busExclusive cycle %0d: got %0d drivers need <=1", cycleNo,
               $countones({Ep, EnableI, CE, EnableA, Eu}));
    end
  endtask

  task automatic step(input vecT v);
    @(negedge MainClock);
    Clear = v.clr;
    BusIn = v.bin;
    sbQ.push_back(v);
    #1;
    checkOut();
    cycleNo++;
  endtask

  task automatic runPart(input logic [7:0] instr, input int first, input int last);
    logic [7:0] bin;
    for (int t = first; t <= last; t++) begin
      bin = (t == 3) ? instr : 8'($urandom);
      step(expT(t, instr, pcModel, bin));
      if (t == 2) pcModel = pcModel + 4'd1;
    end
  endtask

  task automatic clearCycle();
    step(mk(1'b1, 8'($urandom), '0, 1'b0, 1'b0, 4'h0));
    pcModel = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Clear = 1'b1;
    BusIn = 8'h00;

    ldaTab[0] = mk(1'b0, 8'h00, SEP | SLM, 1'b0, 1'b1, 4'h0);
    ldaTab[1] = mk(1'b0, 8'h00, SCP,       1'b0, 1'b0, 4'h0);
    ldaTab[2] = mk(1'b0, 8'h09, SCE | SLI, 1'b0, 1'b0, 4'h0);
    ldaTab[3] = mk(1'b0, 8'h00, SEI | SLM, 1'b0, 1'b1, 4'b1001);
    ldaTab[4] = mk(1'b0, 8'h00, SCE | SLA, 1'b0, 1'b0, 4'h0);
    ldaTab[5] = mk(1'b0, 8'h00, '0,        1'b0, 1'b0, 4'h0);
    ldaTab[6] = mk(1'b0, 8'h00, SEP | SLM, 1'b0, 1'b1, 4'b0001);

    for (int i = 0; i < 3; i++) clearCycle();

    for (int i = 0; i < 7; i++) step(ldaTab[i]);
    pcModel = 4'h1;

    runPart(8'h2A, 2, 6);

    clearCycle();
    runPart(8'hE0, 1, 6);
    runPart(8'hF0, 1, 4);
    for (int i = 0; i < 20; i++) step(mk(1'b0, 8'($urandom), '0, 1'b1, 1'b0, 4'h0));
    clearCycle();

    for (int n = 0; n < 16; n++) runPart(8'h30, 1, 6);
    step(mk(1'b0, 8'h00, SEP | SLM, 1'b0, 1'b1, 4'h0));

    runPart(8'h15, 2, 4);
    clearCycle();
    step(mk(1'b0, 8'h00, SEP | SLM, 1'b0, 1'b1, 4'h0));

    runPart(8'hF0, 2, 3);
    clearCycle();
    step(mk(1'b0, 8'h00, SEP | SLM, 1'b0, 1'b1, 4'h0));
    step(mk(1'b0, 8'h00, SCP,       1'b0, 1'b0, 4'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
